// File: rtl/cubehash_pkg.sv
// Shared types and helpers for the iterative CubeHash engine: FSM state
// encoding, round-input selection, fixed widths, phase lengths and the IV.
package cubehash_pkg;

   localparam int WORD_W  = 32;
   localparam int STATE_W = 1024;
   localparam int INIT_ROUND_MULT = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_WAIT_MSG,
      ST_ABSORB,
      ST_FINAL,
      ST_DONE
   } fsm_t;

   typedef enum logic [1:0] {
      SEL_PLAIN,
      SEL_MSG,
      SEL_FINAL
   } roundSel_t;

   // Length of the initialization and finalization phases in rounds.
   function automatic int initRounds(input int r);
      return INIT_ROUND_MULT * r;
   endfunction

   // Length of one block absorption in rounds, counting the handshake edge.
   function automatic int absorbRounds(input int r);
      return r;
   endfunction

   // Starting state: word0 = h/8, word1 = b, word2 = r, all other words zero.
   function automatic logic [STATE_W-1:0] cubeIv(input int h, input int b, input int r);
      logic [STATE_W-1:0] v;
      v = '0;
      v[STATE_W-1 -: WORD_W]          = WORD_W'(h / 8);
      v[STATE_W-1-WORD_W -: WORD_W]   = WORD_W'(b);
      v[STATE_W-1-2*WORD_W -: WORD_W] = WORD_W'(r);
      return v;
   endfunction

endpackage

// File: rtl/CubeHash_ROUND.sv
// One full CubeHash round as pure combinational logic over the 32-word state.
// Word i lives at i_state[1023-32*i -: 32].
module CubeHash_ROUND
   import cubehash_pkg::*;
(
   input  logic [STATE_W-1:0] i_state,
   output logic [STATE_W-1:0] o_state
);

   logic [WORD_W-1:0] x [32];
   logic [WORD_W-1:0] t;

   // Add/rotate/swap/xor/swap twice with rotations 7 and 11, done in place on x.
   always_comb begin
      t = '0;
      o_state = '0;
      for (int i = 0; i < 32; i++) x[i] = i_state[STATE_W-1-WORD_W*i -: WORD_W];

      for (int i = 0; i < 16; i++) x[i+16] = x[i+16] + x[i];
      for (int i = 0; i < 16; i++) x[i] = {x[i][24:0], x[i][31:25]};
      for (int k = 0; k < 8; k++) begin
         t = x[k]; x[k] = x[k+8]; x[k+8] = t;
      end
      for (int i = 0; i < 16; i++) x[i] = x[i] ^ x[i+16];
      for (int k = 0; k < 8; k++) begin
         t = x[16+(k/2)*4+(k%2)];
         x[16+(k/2)*4+(k%2)] = x[18+(k/2)*4+(k%2)];
         x[18+(k/2)*4+(k%2)] = t;
      end

      for (int i = 0; i < 16; i++) x[i+16] = x[i+16] + x[i];
      for (int i = 0; i < 16; i++) x[i] = {x[i][20:0], x[i][31:21]};
      for (int k = 0; k < 8; k++) begin
         t = x[(k/4)*8+(k%4)];
         x[(k/4)*8+(k%4)] = x[(k/4)*8+(k%4)+4];
         x[(k/4)*8+(k%4)+4] = t;
      end
      for (int i = 0; i < 16; i++) x[i] = x[i] ^ x[i+16];
      for (int k = 0; k < 8; k++) begin
         t = x[16+2*k]; x[16+2*k] = x[17+2*k]; x[17+2*k] = t;
      end

      for (int i = 0; i < 32; i++) o_state[STATE_W-1-WORD_W*i -: WORD_W] = x[i];
   end

endmodule

// File: rtl/cubehash_core.sv
// Iterative CubeHash-r/b-h engine: one round per clock through a single
// CubeHash_ROUND, with init, block absorption, finalization and digest hold.
module cubehash_core
   import cubehash_pkg::*;
#(
   parameter int R = 16,
   parameter int B = 32,
   parameter int H = 512
)(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic           msg_valid,
   output logic           msg_ready,
   input  logic [8*B-1:0] msg_data,
   input  logic           msg_last,
   output logic           busy,
   output logic           digest_valid,
   output logic [H-1:0]   digest
);

   localparam int INIT_CNT = initRounds(R);
   localparam int ABS_CNT  = absorbRounds(R);
   localparam int CNT_W    = $clog2(INIT_CNT);
   localparam logic [CNT_W-1:0] PHASE_LAST  = CNT_W'(INIT_CNT - 1);
   localparam logic [CNT_W-1:0] ABSORB_LAST = CNT_W'((ABS_CNT > 1) ? (ABS_CNT - 2) : 0);
   localparam logic [STATE_W-1:0] IV = cubeIv(H, B, R);

   fsm_t              r_fsm;
   fsm_t              w_nextFsm;
   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_roundIn;
   logic [STATE_W-1:0] w_roundOut;
   logic [STATE_W-1:0] w_msgExt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_last;
   logic              w_load;
   logic              w_round;
   logic              w_cntClr;
   logic              w_cntInc;
   logic              w_accept;
   logic              w_msgReady;
   roundSel_t         w_sel;

   assign w_msgExt = STATE_W'(msg_data) << (STATE_W - 8*B);

   // Pick what the round sees: plain state, state with the block mixed in, or the finalization flip.
   always_comb begin
      w_roundIn = r_state;
      case (w_sel)
         SEL_MSG:   w_roundIn = r_state ^ w_msgExt;
         SEL_FINAL: w_roundIn = r_state ^ STATE_W'(1);
         default:   w_roundIn = r_state;
      endcase
   end

   CubeHash_ROUND u_round (
      .i_state (w_roundIn),
      .o_state (w_roundOut)
   );

   // Next-state and datapath controls; start only restarts from IDLE, WAIT_MSG or DONE.
   always_comb begin
      w_nextFsm  = r_fsm;
      w_load     = 1'b0;
      w_round    = 1'b0;
      w_cntClr   = 1'b0;
      w_cntInc   = 1'b0;
      w_accept   = 1'b0;
      w_msgReady = 1'b0;
      w_sel      = SEL_PLAIN;
      case (r_fsm)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_load    = 1'b1;
               w_cntClr  = 1'b1;
               w_nextFsm = ST_INIT;
            end
         end
         ST_INIT: begin
            w_round = 1'b1;
            if (r_cnt == PHASE_LAST) begin
               w_cntClr  = 1'b1;
               w_nextFsm = ST_WAIT_MSG;
            end else begin
               w_cntInc = 1'b1;
            end
         end
         ST_WAIT_MSG: begin
            if (start) begin
               w_load    = 1'b1;
               w_cntClr  = 1'b1;
               w_nextFsm = ST_INIT;
            end else begin
               w_msgReady = 1'b1;
               if (msg_valid) begin
                  w_accept = 1'b1;
                  w_round  = 1'b1;
                  w_sel    = SEL_MSG;
                  w_cntClr = 1'b1;
                  if (ABS_CNT > 1) w_nextFsm = ST_ABSORB;
                  else w_nextFsm = msg_last ? ST_FINAL : ST_WAIT_MSG;
               end
            end
         end
         ST_ABSORB: begin
            w_round = 1'b1;
            if (r_cnt == ABSORB_LAST) begin
               w_cntClr  = 1'b1;
               w_nextFsm = r_last ? ST_FINAL : ST_WAIT_MSG;
            end else begin
               w_cntInc = 1'b1;
            end
         end
         ST_FINAL: begin
            w_round = 1'b1;
            if (r_cnt == '0) w_sel = SEL_FINAL;
            if (r_cnt == PHASE_LAST) begin
               w_cntClr  = 1'b1;
               w_nextFsm = ST_DONE;
            end else begin
               w_cntInc = 1'b1;
            end
         end
         default: w_nextFsm = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) r_fsm <= ST_IDLE;
      else        r_fsm <= w_nextFsm;
   end

   // Hash state, phase counter and the last-block flag captured at the handshake.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= '0;
         r_cnt   <= '0;
         r_last  <= 1'b0;
      end else begin
         if (w_load)       r_state <= IV;
         else if (w_round) r_state <= w_roundOut;
         if (w_cntClr)      r_cnt <= '0;
         else if (w_cntInc) r_cnt <= r_cnt + CNT_W'(1);
         if (w_accept) r_last <= msg_last;
      end
   end

   assign msg_ready    = w_msgReady;
   assign busy         = (r_fsm == ST_INIT) || (r_fsm == ST_ABSORB) || (r_fsm == ST_FINAL);
   assign digest_valid = (r_fsm == ST_DONE);
   assign digest       = r_state[STATE_W-1 -: H];

endmodule

// File: tb/tb_cubehash_core.sv
// Self-checking bench for cubehash_core: a CubeHash-16/32-512 instance and an
// R=1/B=4/H=256 instance, compared against a byte-level software hash model.
module tb_cubehash_core;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         msg_valid = 1'b0;
   logic         msg_ready;
   logic [255:0] msg_data = '0;
   logic         msg_last = 1'b0;
   logic         busy;
   logic         digest_valid;
   logic [511:0] digest;

   logic         sStart = 1'b0;
   logic         sValid = 1'b0;
   logic         sReady;
   logic [31:0]  sData = '0;
   logic         sLast = 1'b0;
   logic         sBusy;
   logic         sDigestValid;
   logic [255:0] sDigest;

   int checks = 0;
   int failures = 0;
   logic [7:0]   msgBytes [$];
   logic [511:0] emptyDigest;

   always #5 clk = ~clk;

   cubehash_core #(.R(16), .B(32), .H(512)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .msg_valid(msg_valid),
      .msg_ready(msg_ready), .msg_data(msg_data), .msg_last(msg_last),
      .busy(busy), .digest_valid(digest_valid), .digest(digest)
   );

   cubehash_core #(.R(1), .B(4), .H(256)) dutSweep (
      .clk(clk), .rst_n(rst_n), .start(sStart), .msg_valid(sValid),
      .msg_ready(sReady), .msg_data(sData), .msg_last(sLast),
      .busy(sBusy), .digest_valid(sDigestValid), .digest(sDigest)
   );

   // Reference CubeHash round over 32 words: add, rotate, swap by index xor, xor, swap.
   function automatic logic [1023:0] refRound(input logic [1023:0] s);
      logic [31:0] x [32];
      logic [31:0] y [32];
      logic [1023:0] o;
      for (int i = 0; i < 32; i++) x[i] = s[1023-32*i -: 32];
      for (int i = 0; i < 16; i++) x[16+i] = x[16+i] + x[i];
      for (int i = 0; i < 16; i++) x[i] = (x[i] << 7) | (x[i] >> 25);
      for (int i = 0; i < 16; i++) y[i] = x[i ^ 8];
      for (int i = 0; i < 16; i++) x[i] = y[i] ^ x[16+i];
      for (int i = 16; i < 32; i++) y[i] = x[i ^ 2];
      for (int i = 16; i < 32; i++) x[i] = y[i];
      for (int i = 0; i < 16; i++) x[16+i] = x[16+i] + x[i];
      for (int i = 0; i < 16; i++) x[i] = (x[i] << 11) | (x[i] >> 21);
      for (int i = 0; i < 16; i++) y[i] = x[i ^ 4];
      for (int i = 0; i < 16; i++) x[i] = y[i] ^ x[16+i];
      for (int i = 16; i < 32; i++) y[i] = x[i ^ 1];
      for (int i = 16; i < 32; i++) x[i] = y[i];
      for (int i = 0; i < 32; i++) o[1023-32*i -: 32] = x[i];
      return o;
   endfunction

   // Full CubeHash-r/b-h of msgBytes (already padded, whole blocks); returns the final 1024-bit state.
   function automatic logic [1023:0] refHash(input int r, input int b, input int h);
      logic [1023:0] s;
      logic [31:0] w;
      int nb;
      s = '0;
      s[1023 -: 32] = 32'(h / 8);
      s[991 -: 32]  = 32'(b);
      s[959 -: 32]  = 32'(r);
      for (int n = 0; n < 10*r; n++) s = refRound(s);
      nb = msgBytes.size() / b;
      for (int blk = 0; blk < nb; blk++) begin
         for (int j = 0; j < b/4; j++) begin
            w = 32'(msgBytes[blk*b+4*j]) + (32'(msgBytes[blk*b+4*j+1]) * 256)
              + (32'(msgBytes[blk*b+4*j+2]) * 65536) + (32'(msgBytes[blk*b+4*j+3]) * 16777216);
            s[1023-32*j -: 32] = s[1023-32*j -: 32] ^ w;
         end
         for (int n = 0; n < r; n++) s = refRound(s);
      end
      s[0] = ~s[0];
      for (int n = 0; n < 10*r; n++) s = refRound(s);
      return s;
   endfunction

   function automatic logic [255:0] packBlock(input int blk);
      logic [255:0] d;
      for (int j = 0; j < 8; j++)
         d[255-32*j -: 32] = {msgBytes[blk*32+4*j+3], msgBytes[blk*32+4*j+2],
                              msgBytes[blk*32+4*j+1], msgBytes[blk*32+4*j]};
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Count busy cycles until msg_ready shows up (bounded).
   task automatic waitInit(output int n);
      int k;
      n = 0;
      k = 0;
      while (msg_ready !== 1'b1 && k < 1000) begin
         if (busy === 1'b1) n++;
         tick();
         k++;
      end
   endtask

   // Offer one block, let it be accepted, then count cycles until ready or digest_valid (bounded).
   task automatic applyStimulus(input logic [255:0] data, input logic last, input int bound, output int gap);
      int k;
      msg_data  = data;
      msg_last  = last;
      msg_valid = 1'b1;
      k = 0;
      while (msg_ready !== 1'b1 && k < 400) begin
         tick();
         k++;
      end
      tick();
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      msg_data  = {8{$urandom()}};
      gap = 0;
      while (msg_ready !== 1'b1 && digest_valid !== 1'b1 && gap < bound) begin
         tick();
         gap++;
      end
   endtask

   task automatic test_reset();
      int n;
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (msg_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b want=0", msg_ready); end
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      checks++; if (digest_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_dvalid got=%b want=0", digest_valid); end
      checks++; if (digest !== '0) begin failures++; $display("[TB] FAIL reset_digest got=%h want=0", digest); end
      rst_n = 1'b1;
      tick();
      checks++; if (busy !== 1'b0 || msg_ready !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset busy=%b ready=%b want 0 0", busy, msg_ready); end
      doStart();
      waitInit(n);
      checks++; if (n != 160) begin failures++; $display("[TB] FAIL init_busy_cycles got=%0d want=160", n); end
      checks++; if (msg_ready !== 1'b1) begin failures++; $display("[TB] FAIL init_ready got=%b want=1", msg_ready); end
   endtask

   // Empty message: one padded block 0x80,0,...; digest_valid 11R-1 cycles after the accept-cycle ends.
   task automatic test_empty();
      int n, gap;
      logic [1023:0] exp;
      msgBytes.delete();
      msgBytes.push_back(8'h80);
      for (int i = 1; i < 32; i++) msgBytes.push_back(8'h00);
      doStart();
      waitInit(n);
      checks++; if (n != 160) begin failures++; $display("[TB] FAIL empty_init got=%0d want=160", n); end
      applyStimulus(packBlock(0), 1'b1, 400, gap);
      checks++; if (gap != 175) begin failures++; $display("[TB] FAIL empty_latency got=%0d want=175", gap); end
      exp = refHash(16, 32, 512);
      emptyDigest = exp[1023 -: 512];
      checks++; if (digest_valid !== 1'b1) begin failures++; $display("[TB] FAIL empty_dvalid got=%b want=1", digest_valid); end
      checks++; if (digest !== emptyDigest) begin failures++; $display("[TB] FAIL empty_digest got=%h want=%h", digest, emptyDigest); end
      msg_valid = 1'b1;
      repeat (5) tick();
      msg_valid = 1'b0;
      checks++; if (digest !== emptyDigest || digest_valid !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("[TB] FAIL done_hold got=%h valid=%b busy=%b want=%h 1 0", digest, digest_valid, busy, emptyDigest);
      end
   endtask

   task automatic test_three_blocks();
      int n, gap;
      logic [1023:0] exp;
      msgBytes.delete();
      for (int i = 0; i < 96; i++) msgBytes.push_back(8'(i));
      doStart();
      waitInit(n);
      checks++; if (n != 160) begin failures++; $display("[TB] FAIL three_init got=%0d want=160", n); end
      for (int blk = 0; blk < 3; blk++) begin
         applyStimulus(packBlock(blk), blk == 2, 400, gap);
         checks++; if (gap != ((blk == 2) ? 175 : 15)) begin
            failures++; $display("[TB] FAIL three_gap%0d got=%0d want=%0d", blk, gap, (blk == 2) ? 175 : 15);
         end
      end
      exp = refHash(16, 32, 512);
      checks++; if (digest !== exp[1023 -: 512]) begin failures++; $display("[TB] FAIL three_digest got=%h want=%h", digest, exp[1023 -: 512]); end
   endtask

   task automatic test_start_collision();
      int n, gap;
      msgBytes.delete();
      msgBytes.push_back(8'h80);
      for (int i = 1; i < 32; i++) msgBytes.push_back(8'h00);
      doStart();
      waitInit(n);
      msg_data  = packBlock(0);
      msg_last  = 1'b1;
      msg_valid = 1'b1;
      start     = 1'b1;
      #1;
      checks++; if (msg_ready !== 1'b0) begin failures++; $display("[TB] FAIL collide_ready got=%b want=0", msg_ready); end
      tick();
      start     = 1'b0;
      msg_valid = 1'b0;
      waitInit(n);
      checks++; if (n != 160) begin failures++; $display("[TB] FAIL collide_restart got=%0d want=160", n); end
      applyStimulus(packBlock(0), 1'b1, 400, gap);
      checks++; if (digest !== emptyDigest || gap != 175) begin
         failures++; $display("[TB] FAIL collide_digest got=%h gap=%0d want=%h 175", digest, gap, emptyDigest);
      end
   endtask

   task automatic test_reset_mid_final();
      int n, gap, rises;
      logic [1023:0] exp;
      msgBytes.delete();
      for (int i = 0; i < 32; i++) msgBytes.push_back(8'($urandom()));
      doStart();
      waitInit(n);
      applyStimulus(packBlock(0), 1'b1, 60, gap);
      checks++; if (gap != 60 || busy !== 1'b1) begin failures++; $display("[TB] FAIL midfinal_state gap=%0d busy=%b want 60 1", gap, busy); end
      rst_n = 1'b0;
      tick();
      checks++; if (msg_ready !== 1'b0 || busy !== 1'b0 || digest_valid !== 1'b0 || digest !== '0) begin
         failures++; $display("[TB] FAIL abort_outputs ready=%b busy=%b valid=%b digest=%h want all 0", msg_ready, busy, digest_valid, digest);
      end
      rst_n = 1'b1;
      rises = 0;
      for (int i = 0; i < 200; i++) begin
         if (digest_valid !== 1'b0) rises++;
         tick();
      end
      checks++; if (rises != 0) begin failures++; $display("[TB] FAIL abort_no_digest got=%0d want=0", rises); end
      doStart();
      waitInit(n);
      applyStimulus(packBlock(0), 1'b1, 400, gap);
      exp = refHash(16, 32, 512);
      checks++; if (digest !== exp[1023 -: 512] || digest_valid !== 1'b1) begin
         failures++; $display("[TB] FAIL after_abort_digest got=%h want=%h", digest, exp[1023 -: 512]);
      end
   endtask

   task automatic test_random();
      int n, gap, nb;
      logic [1023:0] exp;
      for (int it = 0; it < 3; it++) begin
         nb = $urandom_range(1, 3);
         msgBytes.delete();
         for (int i = 0; i < 32*nb; i++) msgBytes.push_back(8'($urandom()));
         doStart();
         waitInit(n);
         for (int blk = 0; blk < nb; blk++) begin
            repeat ($urandom_range(0, 3)) tick();
            applyStimulus(packBlock(blk), blk == nb-1, 400, gap);
         end
         exp = refHash(16, 32, 512);
         checks++; if (digest !== exp[1023 -: 512] || digest_valid !== 1'b1) begin
            failures++; $display("[TB] FAIL random%0d_digest got=%h want=%h", it, digest, exp[1023 -: 512]);
         end
      end
   endtask

   task automatic test_param_sweep();
      int n, k;
      logic [1023:0] exp;
      checks++; if (sBusy !== 1'b0 || sDigestValid !== 1'b0 || sDigest !== '0) begin
         failures++; $display("[TB] FAIL sweep_idle busy=%b valid=%b digest=%h want 0", sBusy, sDigestValid, sDigest);
      end
      msgBytes.delete();
      for (int i = 0; i < 8; i++) msgBytes.push_back(8'($urandom()));
      sStart = 1'b1;
      tick();
      sStart = 1'b0;
      n = 0;
      k = 0;
      while (sReady !== 1'b1 && k < 100) begin
         if (sBusy === 1'b1) n++;
         tick();
         k++;
      end
      checks++; if (n != 10) begin failures++; $display("[TB] FAIL sweep_init got=%0d want=10", n); end
      sData  = {msgBytes[3], msgBytes[2], msgBytes[1], msgBytes[0]};
      sLast  = 1'b0;
      sValid = 1'b1;
      tick();
      sValid = 1'b0;
      checks++; if (sReady !== 1'b1 || sBusy !== 1'b0) begin failures++; $display("[TB] FAIL sweep_no_absorb ready=%b busy=%b want 1 0", sReady, sBusy); end
      sData  = {msgBytes[7], msgBytes[6], msgBytes[5], msgBytes[4]};
      sLast  = 1'b1;
      sValid = 1'b1;
      tick();
      sValid = 1'b0;
      sLast  = 1'b0;
      n = 0;
      while (sDigestValid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++; if (n != 10) begin failures++; $display("[TB] FAIL sweep_latency got=%0d want=10", n); end
      exp = refHash(1, 4, 256);
      checks++; if (sDigest !== exp[1023 -: 256]) begin failures++; $display("[TB] FAIL sweep_digest got=%h want=%h", sDigest, exp[1023 -: 256]); end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_three_blocks();
      test_start_collision();
      test_reset_mid_final();
      test_random();
      test_param_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
